// File: rtl/shift_rx8_pkg.sv
// Shared constants for the shift-register serial link: word width, receiver
// FSM encoding and the bit-counter width helper.
package shift_rx8_pkg;

  // Word length shared by the transmit and receive sides of the link.
  localparam int SHIFT_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  // Counter wide enough to index every bit position of a word.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/shift_rx8_sipo_core.sv
// Shift register and bit counter that assemble one LSB-first word, inserting
// each new bit at the MSB and flagging the bit that completes a word.
module sipo_core
  import shift_rx8_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic                        shift,
  input  logic                        s_in,
  output logic [WIDTH-1:0]            shreg,
  output logic [cnt_width(WIDTH)-1:0] bit_cnt,
  output logic                        done
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // A clear restarts at bit 0, so a bit shifted on the same cycle can never complete a word.
  assign done = shift && !clr && (bit_cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (clr) begin
      shreg   <= shift ? {s_in, {(WIDTH-1){1'b0}}} : '0;
      bit_cnt <= shift ? CW'(1) : '0;
    end else if (shift) begin
      shreg   <= {s_in, shreg[WIDTH-1:1]};
      bit_cnt <= done ? '0 : bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/shift_rx8.sv
// Serial-to-parallel receiver: frames LSB-first words after a sync pulse and
// presents them on a valid/ready port with a sticky overrun flag.
module shift_rx8
  import shift_rx8_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sync,
  input  logic                        bit_valid,
  input  logic                        s_in,
  input  logic                        out_ready,
  input  logic                        clr_ovr,
  output logic [WIDTH-1:0]            p_out,
  output logic                        out_valid,
  output logic                        overrun,
  output logic [cnt_width(WIDTH)-1:0] bit_cnt
);

  state_t           state;
  state_t           state_next;
  logic             shift;
  logic             clr;
  logic             done;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] word;
  logic             accept;
  logic             set_ovr;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Bits are ignored until the first sync; after that the stream is continuous.
  always_comb begin
    state_next = state;
    clr        = sync;
    shift      = 1'b0;
    if (state == IDLE) begin
      shift = bit_valid && sync;
      if (sync) state_next = RECV;
    end else begin
      shift = bit_valid;
    end
  end

  sipo_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .shift   (shift),
    .s_in    (s_in),
    .shreg   (shreg),
    .bit_cnt (bit_cnt),
    .done    (done)
  );

  assign word    = {s_in, shreg[WIDTH-1:1]};
  assign accept  = done && (!out_valid || out_ready);
  assign set_ovr = done && out_valid && !out_ready;

  // A stalled word is held untouched; a word arriving behind it is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_out     <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (accept) begin
        p_out     <= word;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (set_ovr)      overrun <= 1'b1;
      else if (clr_ovr) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_rx8.sv
// Table-driven bench for shift_rx8: every cycle applies one vector and checks
// all outputs one time unit after the rising edge.
module tb_shift_rx8;

  logic       clk = 1'b0;
  logic       rst_n, sync, bit_valid, s_in, out_ready, clr_ovr;
  logic [7:0] p_out;
  logic       out_valid, overrun;
  logic [2:0] bit_cnt;

  typedef struct {
    logic       rst_n, sync, bit_valid, s_in, out_ready, clr_ovr;
    logic [7:0] exp_p;
    logic       exp_v, exp_o;
    logic [2:0] exp_c;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  shift_rx8 #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sync      (sync),
    .bit_valid (bit_valid),
    .s_in      (s_in),
    .out_ready (out_ready),
    .clr_ovr   (clr_ovr),
    .p_out     (p_out),
    .out_valid (out_valid),
    .overrun   (overrun),
    .bit_cnt   (bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic addVec(input logic r, sy, bv, si, rdy, clr,
                        input logic [7:0] ep, input logic ev, eo,
                        input logic [2:0] ec);
    vec_t v;
    v.rst_n = r;  v.sync = sy; v.bit_valid = bv; v.s_in = si;
    v.out_ready = rdy; v.clr_ovr = clr;
    v.exp_p = ep; v.exp_v = ev; v.exp_o = eo; v.exp_c = ec;
    tbl.push_back(v);
  endtask

  // Pushes one word LSB first; mid_* hold while the word assembles, end_* after its last bit.
  task automatic addWord(input logic [7:0] w, input logic first_sync, rdy, clr,
                         input logic [7:0] mid_p, input logic mid_v, mid_o,
                         input logic [7:0] end_p, input logic end_v, end_o,
                         input int gap);
    for (int i = 0; i < 8; i++) begin
      if (i == 7)
        addVec(1, 0, 1, w[i], rdy, clr, end_p, end_v, end_o, 3'd0);
      else begin
        addVec(1, (i == 0) && first_sync, 1, w[i], rdy, clr, mid_p, mid_v, mid_o, 3'(i + 1));
        for (int g = 0; g < gap; g++)
          addVec(1, 0, 0, 1'b1, rdy, clr, mid_p, mid_v, mid_o, 3'(i + 1));
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst_n = v.rst_n; sync = v.sync; bit_valid = v.bit_valid;
    s_in = v.s_in; out_ready = v.out_ready; clr_ovr = v.clr_ovr;
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    checks += 4;
    if (p_out !== v.exp_p) begin
      errors++;
      $display("[TB] FAIL vec %0d p_out: got %h expected %h", idx, p_out, v.exp_p);
    end
    if (out_valid !== v.exp_v) begin
      errors++;
      $display("[TB] FAIL vec %0d out_valid: got %b expected %b", idx, out_valid, v.exp_v);
    end
    if (overrun !== v.exp_o) begin
      errors++;
      $display("[TB] FAIL vec %0d overrun: got %b expected %b", idx, overrun, v.exp_o);
    end
    if (bit_cnt !== v.exp_c) begin
      errors++;
      $display("[TB] FAIL vec %0d bit_cnt: got %0d expected %0d", idx, bit_cnt, v.exp_c);
    end
  endtask

  initial begin
    // Reset for two cycles; sync during reset must be overridden.
    addVec(0, 1, 1, 1, 1, 0, 8'h00, 0, 0, 3'd0);
    addVec(0, 0, 1, 1, 1, 0, 8'h00, 0, 0, 3'd0);
    // IDLE ignores bits without sync.
    for (int i = 0; i < 8; i++) addVec(1, 0, 1, 1, 1, 0, 8'h00, 0, 0, 3'd0);

    // Single word A5, then one-cycle handshake drain.
    addVec(1, 1, 0, 0, 1, 0, 8'h00, 0, 0, 3'd0);
    addWord(8'hA5, 0, 1, 0, 8'h00, 0, 0, 8'hA5, 1, 0, 0);
    addVec(1, 0, 0, 0, 1, 0, 8'hA5, 0, 0, 3'd0);

    // sync together with the first bit, back-to-back words.
    addWord(8'h3C, 1, 1, 0, 8'hA5, 0, 0, 8'h3C, 1, 0, 0);
    addWord(8'hF0, 0, 1, 0, 8'h3C, 0, 0, 8'hF0, 1, 0, 0);
    addVec(1, 0, 0, 0, 1, 0, 8'hF0, 0, 0, 3'd0);

    // Backpressure: second word dropped, first held stable.
    addWord(8'h12, 0, 0, 0, 8'hF0, 0, 0, 8'h12, 1, 0, 0);
    addWord(8'h34, 0, 0, 0, 8'h12, 1, 0, 8'h12, 1, 1, 0);
    addVec(1, 0, 0, 0, 0, 0, 8'h12, 1, 1, 3'd0);
    addVec(1, 0, 0, 0, 1, 0, 8'h12, 0, 1, 3'd0);
    addVec(1, 0, 0, 0, 0, 1, 8'h12, 0, 0, 3'd0);

    // Mid-word resync: three partial bits discarded.
    addVec(1, 0, 1, 1, 1, 0, 8'h12, 0, 0, 3'd1);
    addVec(1, 0, 1, 1, 1, 0, 8'h12, 0, 0, 3'd2);
    addVec(1, 0, 1, 1, 1, 0, 8'h12, 0, 0, 3'd3);
    addVec(1, 1, 0, 0, 1, 0, 8'h12, 0, 0, 3'd0);
    addWord(8'h81, 0, 1, 0, 8'h12, 0, 0, 8'h81, 1, 0, 0);

    // Overrun set wins over a simultaneous clr_ovr.
    addWord(8'h55, 0, 0, 1, 8'h81, 1, 0, 8'h81, 1, 1, 0);
    addVec(1, 0, 0, 0, 1, 1, 8'h81, 0, 0, 3'd0);

    // Gapped word, then reset in the middle of the next word.
    addWord(8'h5A, 0, 1, 0, 8'h81, 0, 0, 8'h5A, 1, 0, 3);
    addVec(1, 0, 1, 1, 1, 0, 8'h5A, 0, 0, 3'd1);
    addVec(1, 0, 1, 1, 1, 0, 8'h5A, 0, 0, 3'd2);
    addVec(1, 0, 1, 1, 1, 0, 8'h5A, 0, 0, 3'd3);
    addVec(1, 0, 1, 1, 1, 0, 8'h5A, 0, 0, 3'd4);
    addVec(0, 0, 1, 1, 1, 0, 8'h00, 0, 0, 3'd0);
    // Back in IDLE after reset: bits ignored again.
    addVec(1, 0, 1, 1, 1, 0, 8'h00, 0, 0, 3'd0);
    addVec(1, 0, 1, 1, 1, 0, 8'h00, 0, 0, 3'd0);

    applyStimulus(tbl[0]);
    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
      @(posedge clk);
      #1;
      checkOutput(i, tbl[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_rx8.md
# shift_rx8

Serial-to-parallel receiver for the LSB-first bit stream produced by the team's 8-bit parallel-load shift register. In that register, bit 0 is the serial output and the word shifts right once per clock. This block takes one serial bit per qualified cycle and assembles each word by shifting right, inserting at the MSB. It presents each completed word on a valid/ready output port and flags overrun when a completed word cannot be accepted. It is the receive-side endpoint of the serial link between two shift-register stages in the lab datapath.

## Interface
- WIDTH, 8, word length in bits (≥2)
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset; sampled on rising edge of clk
- sync  input  1  frame-alignment pulse; restarts word assembly at bit 0
- bit_valid  input  1  s_in carries a valid bit this cycle
- s_in  input  1  serial data, LSB of each word first
- out_ready  input  1  consumer accepts p_out this cycle
- clr_ovr  input  1  clears the sticky overrun flag
- p_out  output  WIDTH  last completed word
- out_valid  output  1  p_out holds an unconsumed word
- overrun  output  1  sticky: a completed word was dropped
- bit_cnt  output  $clog2(WIDTH)  bits collected in the current word

## Operation
- FSM states: IDLE and RECV.
  - IDLE: bit_valid is ignored and bit_cnt holds 0.
  - sync in any state: next state is RECV, shreg is cleared and bit_cnt is cleared.
  - No path from RECV back to IDLE except reset.
- Shift rule: in RECV, or on a sync cycle, bit_valid=1 updates the word as follows.
  - shreg <= {s_in, shreg[WIDTH-1:1]}.
  - bit_cnt <= bit_cnt+1.
  - If sync and bit_valid are both high, s_in is bit 0 of the new word and bit_cnt becomes 1.
- Word completion: a valid bit arrives while bit_cnt==WIDTH-1.
  - The completed word is {s_in, shreg[WIDTH-1:1]}.
  - bit_cnt wraps to 0 and the state stays RECV, so the stream is continuous.
- Output register: valid/ready semantics.
  - A handshake occurs when out_valid=1 and out_ready=1 on the same cycle.
  - When a word completes and either out_valid=0 or out_ready=1, load p_out with the word and set out_valid=1.
  - When a word completes while out_valid=1 and out_ready=0, keep p_out unchanged, drop the new word and set overrun=1.
  - On a handshake with no word completing, set out_valid=0. p_out keeps its value.
- Stability: while out_valid=1 and out_ready=0, p_out must not change.
- Overrun flag:
  - Cleared only by clr_ovr=1 or by reset.
  - If a set event and clr_ovr occur on the same cycle, set wins.
- Mid-word sync: discards the partial word and leaves the output register and overrun untouched.

## Timing
- Reset (rst_n=0 at a rising edge): state=IDLE, shreg=0, bit_cnt=0, p_out=0, out_valid=0, overrun=0. Reset overrides every other input.
- Latency: out_valid and p_out update at the same rising edge that samples the last bit. They are visible in the following cycle.
- Throughput: one bit per cycle. A new word is at most every WIDTH cycles. With out_ready held at 1, no overrun is possible.
- Gaps: bit_valid=0 cycles stall assembly indefinitely with no timeout.
- Combinational paths: none from inputs to outputs. All outputs are registered.

## Structure
- Shared package/header: WIDTH default (8), the FSM state encoding (IDLE=1'b0, RECV=1'b1), and the counter-width function. The transmit-side block uses the same WIDTH constant.
- Sub-module sipo_core:
  - Contains the shift register plus bit counter.
  - Inputs: clk, rst_n, clr, shift, s_in.
  - Outputs: shreg, bit_cnt, done.
- Top level: owns the FSM, output register, handshake and overrun logic.

## Test plan
- Reset and IDLE: hold rst_n=0 for 2 cycles, then apply bit_valid=1 without sync for 8 cycles → all outputs 0, bit_cnt stays 0.
- Single word: sync, then bits 1,0,1,0,0,1,0,1 with out_ready=1 → p_out=8'hA5, out_valid=1 for exactly 1 cycle, overrun=0.
- Back-to-back with sync+bit same cycle: sync with bit_valid=1 on the first bit, then stream 8'h3C followed immediately by 8'hF0 with out_ready=1 → p_out=8'h3C, then 8'hF0 eight cycles later.
- Backpressure and overrun:
  - Setup: out_ready=0, receive 8'h12 then 8'h34.
  - Required: p_out stays 8'h12, out_valid=1, overrun=1.
  - Then assert out_ready=1 for 1 cycle: out_valid=0.
  - Then pulse clr_ovr: overrun=0.
- Mid-word resync: send 3 bits, pulse sync, then send 8'h81 → p_out=8'h81, and the partial bits never appear on p_out.
- Reset mid-word and bit gaps:
  - Send 8'h5A with bit_valid deasserted for 3 cycles between each bit → p_out=8'h5A.
  - Then send 4 bits and assert rst_n=0 → all outputs 0 at the next cycle.
